// File: rtl/wrapper_pkg.sv
// Shared wrapper definitions: opcode constants and the instruction decoder used
// by both the WIR and the wrapper data-register path.
package wrapper_pkg;

  localparam int IR_WIDTH_DEFAULT = 3;

  localparam int unsigned WS_BYPASS = 0;
  localparam int unsigned WS_EXTEST = 1;
  localparam int unsigned WS_INTEST = 2;
  localparam int unsigned WS_SAMPLE = 3;

  typedef enum logic [1:0] {
    OP_BYPASS,
    OP_EXTEST,
    OP_INTEST,
    OP_SAMPLE
  } ws_op_e;

  // Any code outside the defined set falls back to bypass so an unknown
  // instruction never disturbs the functional path.
  function automatic ws_op_e ws_decode(input int unsigned code);
    case (code)
      WS_EXTEST: return OP_EXTEST;
      WS_INTEST: return OP_INTEST;
      WS_SAMPLE: return OP_SAMPLE;
      default:   return OP_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/wrapper_data_path_wbr_cell.sv
// One wrapper boundary register cell: shift-stage flop, update-stage flop and
// the functional/test output mux.
module wbr_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic cap_en,
  input  logic shf_en,
  input  logic upd_en,
  input  logic test_mode,
  input  logic cfi,
  input  logic si,
  output logic shr_q,
  output logic cfo
);

  logic upd_q;

  // Shift stage: capture has priority; enables are already qualified upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      shr_q <= 1'b0;
    else if (cap_en) shr_q <= cfi;
    else if (shf_en) shr_q <= si;
  end

  // Update stage samples the pre-edge shift value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      upd_q <= 1'b0;
    else if (upd_en) upd_q <= shr_q;
  end

  // Functional output follows the update stage only in test mode.
  always_comb cfo = test_mode ? upd_q : cfi;

endmodule

// File: rtl/wrapper_data_path.sv
// Wrapper data-register path: WBY bypass bit, NCELLS-cell WBR and the WSO mux.
module wrapper_data_path
  import wrapper_pkg::*;
#(
  parameter int NCELLS   = 8,
  parameter int IR_WIDTH = IR_WIDTH_DEFAULT
) (
  input  logic                WRCK,
  input  logic                WRSTN,
  input  logic                WSI,
  input  logic                SelectWIR,
  input  logic                CaptureWR,
  input  logic                ShiftWR,
  input  logic                UpdateWR,
  input  logic [IR_WIDTH-1:0] wir_instr,
  input  logic                wir_so,
  input  logic [NCELLS-1:0]   cfi,
  output logic [NCELLS-1:0]   cfo,
  output logic                WSO,
  output logic                wbr_active,
  output logic                test_mode
);

  ws_op_e            op;
  logic              wbr_sel, byp_sel;
  logic              cap_en, shf_en, upd_en;
  logic [NCELLS-1:0] shr, si;
  logic              wby;

  // Decode is purely combinational so an instruction change takes effect at once.
  always_comb begin
    op         = ws_decode(32'(wir_instr));
    wbr_active = (op != OP_BYPASS);
    test_mode  = (op == OP_EXTEST) || (op == OP_INTEST);
    wbr_sel    = !SelectWIR && wbr_active;
    byp_sel    = !SelectWIR && !wbr_active;
    cap_en     = wbr_sel && CaptureWR;
    shf_en     = wbr_sel && ShiftWR && !CaptureWR;
    upd_en     = wbr_sel && UpdateWR;
  end

  // WSI enters the top cell; cell 0 is the exit toward WSO.
  assign si = {WSI, shr[NCELLS-1:1]};

  for (genvar g = 0; g < NCELLS; g++) begin : g_cell
    wbr_cell u_cell (
      .clk      (WRCK),
      .rst_n    (WRSTN),
      .cap_en   (cap_en),
      .shf_en   (shf_en),
      .upd_en   (upd_en),
      .test_mode(test_mode),
      .cfi      (cfi[g]),
      .si       (si[g]),
      .shr_q    (shr[g]),
      .cfo      (cfo[g])
    );
  end

  // Bypass bit: capture clears it, shift loads WSI.
  always_ff @(posedge WRCK or negedge WRSTN) begin
    if (!WRSTN)                    wby <= 1'b0;
    else if (byp_sel && CaptureWR) wby <= 1'b0;
    else if (byp_sel && ShiftWR)   wby <= WSI;
  end

  // Serial output source follows the active path combinationally.
  always_comb begin
    if (SelectWIR)       WSO = wir_so;
    else if (wbr_active) WSO = shr[0];
    else                 WSO = wby;
  end

endmodule

// File: doc/wrapper_data_path.md
# wrapper_data_path

Wrapper data-register path that sits directly downstream of the wrapper instruction register (WIR). Consumes the WIR's updated instruction, WIR serial output and the wrapper serial control (WSC) strobes. Implements the 1-bit wrapper bypass register (WBY) and an NCELLS-cell wrapper boundary register (WBR) with shift and update stages. Drives the single wrapper serial output WSO and the functional outputs cfo.

## Interface
- NCELLS, 8, number of WBR cells (≥2)
- IR_WIDTH, 3, width of WIR instruction bus

- WRCK  in  1  wrapper clock; all state on rising edge
- WRSTN  in  1  asynchronous active-low reset
- WSI  in  1  wrapper serial input
- SelectWIR  in  1  1 = WIR is the active serial path, WDR ops inhibited
- CaptureWR  in  1  capture strobe
- ShiftWR  in  1  shift strobe
- UpdateWR  in  1  update strobe
- wir_instr  in  IR_WIDTH  current WIR update-stage instruction
- wir_so  in  1  WIR serial output
- cfi  in  NCELLS  functional inputs to the WBR cells
- cfo  out  NCELLS  functional outputs of the WBR cells
- WSO  out  1  wrapper serial output
- wbr_active  out  1  1 when the decoded instruction selects the WBR
- test_mode  out  1  1 when cfo is driven from the WBR update stage

## Operation
- Instruction decode (combinational from wir_instr): 0 WS_BYPASS, 1 WS_EXTEST, 2 WS_INTEST, 3 WS_SAMPLE; every other code decodes as WS_BYPASS.
- wbr_active = EXTEST|INTEST|SAMPLE; test_mode = EXTEST|INTEST.
- State: shr[NCELLS-1:0] (shift stage), upd[NCELLS-1:0] (update stage), wby (1 bit).
- SelectWIR=1: shr, upd, wby hold regardless of strobes; WSO = wir_so.
- SelectWIR=0, wbr_active=0 (bypass): CaptureWR loads wby←0; else ShiftWR loads wby←WSI. shr/upd hold. WSO = wby.
- SelectWIR=0, wbr_active=1: CaptureWR loads shr←cfi; else ShiftWR loads shr←{WSI, shr[NCELLS-1:1]} (WSI enters cell NCELLS-1, cell 0 exits first). UpdateWR loads upd←shr (pre-edge value). wby holds. WSO = shr[0].
- Simultaneous CaptureWR and ShiftWR: capture wins. UpdateWR concurrent with capture or shift: upd takes the shr value from before the edge; shr takes the capture/shift value.
- cfo = test_mode ? upd : cfi (combinational mux).

## Timing
- Reset (WRSTN low, asynchronous, any time including mid-shift): shr=0, upd=0, wby=0. Outputs follow combinationally: cfo=cfi unless test_mode, in which case cfo=0. WSO reflects the selected source with reset state.
- Release is synchronous to the next rising WRCK; no strobe acts on the release edge's preceding asynchronous window.
- Bypass latency: WSI to WSO is 1 WRCK cycle.
- WBR latency: WSI to WSO is NCELLS cycles; shr[0] is visible on WSO immediately after capture.
- Update: cfo changes on the edge where UpdateWR is sampled high (test_mode=1).
- Instruction change: wbr_active, test_mode, WSO source and cfo mux switch combinationally, with no cycle delay. Register contents are preserved across instruction changes.

## Structure
- Shared package wrapper_pkg: IR_WIDTH default, opcode constants WS_BYPASS/WS_EXTEST/WS_INTEST/WS_SAMPLE, and decode function. The WIR uses the same package.
- One natural sub-module: wbr_cell, a per-cell capture/shift/update flop pair with mode mux. The WBR is instantiated NCELLS times via generate. WBY and the WSO mux live in the top.

## Test plan
- Reset mid-operation: SAMPLE, shift 3 cycles of 1, then pulse WRSTN low → shr=0, upd=0, wby=0 immediately. After release with ShiftWR, WSO=0 until the new data arrives.
- Bypass: wir_instr=0, ShiftWR=1, WSI=1,0,1,1 → WSO=0(reset),1,0,1,1 each one cycle delayed. wir_instr=3'b111 gives identical result.
- SAMPLE: cfi=8'hA5, one CaptureWR, then 8 ShiftWR → WSO sequence 1,0,1,0,0,1,0,1. cfo tracks cfi throughout.
- EXTEST: shift 8'h3C LSB-first (8 cycles), UpdateWR → cfo=8'h3C after that edge. Switch wir_instr to 0 → cfo=cfi in the same cycle. Switch back to EXTEST → cfo=8'h3C again.
- SelectWIR=1 with ShiftWR/CaptureWR/UpdateWR toggling for 5 cycles → shr, upd, wby unchanged. WSO equals wir_so every cycle.
- CaptureWR and ShiftWR both high in SAMPLE with cfi=8'hFF, plus concurrent UpdateWR → shr=8'hFF, upd=previous shr.
